dtlb_wr_sched: RTL and testbench
================================

# dtlb_wr_sched

Write-port scheduler for the 8-way × 16-set data TLB. It arbitrates three requesters onto the DTLB's single write port: page-walk refills, single-address invalidates and full-TLB flushes. It sequences a flush as a 128-step forced-way invalidate sweep. It also holds all requesters off for the DTLB's 16-cycle post-reset init window. It sits between the page walker / invalidate queue and the DTLB write inputs, and steals DTLB read port 0 when an invalidate needs a hit lookup.

## Interface
Parameters:
- AW, 51: virtual tag/index width of the DTLB write address (set index is bits [3:0]).
- DW, `dtlbData_width: width of one DTLB data word.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- rf_valid  in  1  refill request.
- rf_ready  out  1  refill accepted when rf_valid & rf_ready.
- rf_addr  in  AW  refill tag/index.
- rf_data0/1/2  in  DW each  three consecutive PTE data words.
- iv_valid  in  1  single-address invalidate request.
- iv_ready  out  1  invalidate accepted.
- iv_addr  in  AW  address to invalidate.
- fl_req  in  1  level flush request; sampled in IDLE.
- fl_busy  out  1  flush sweep in progress.
- fl_done  out  1  one-cycle pulse after the last sweep write.
- write_addr  out  AW  DTLB write address.
- write_data0/1/2  out  DW each  DTLB write data.
- write_wen  out  1  DTLB write strobe.
- write_xstant  out  1  write into an existing or forced way rather than the LRU way.
- write_invl  out  1  write an invalid entry.
- force_way_en  out  1  force the write to force_way.
- force_way  out  3  forced way number.
- p0_steal  out  1  top level muxes p0_addr onto DTLB read port 0.
- p0_addr  out  AW  stolen read-port-0 address (same value as write_addr).

## Operation
- States:
  - INIT: 16 cycles after reset release, matching the DTLB init sweep; both ready outputs are 0.
  - IDLE: single-cycle issue state.
  - FLUSH: 128-step sweep.
  - FLDONE: one cycle; pulses fl_done and returns to IDLE.
- IDLE priority: fl_req > iv_valid > rf_valid. Only one request is accepted per cycle.
  - If fl_req=1, both ready outputs are 0 that cycle and the next state is FLUSH.
  - Otherwise iv_ready=1, and rf_ready = ~iv_valid.
- Refill accepted in cycle N → cycle N+1 drives:
  - write_wen=1, xstant=0, invl=0, force_way_en=0;
  - addr/data taken from the request. The DTLB picks the LRU way.
- Invalidate accepted in cycle N → cycle N+1 drives:
  - write_wen=1, xstant=1, invl=1, force_way_en=0;
  - p0_steal=1 with p0_addr=write_addr=iv_addr;
  - data outputs 0.
  - A DTLB miss means no way is written. That is legal and not reported.
- FLUSH uses a 7-bit counter {set[3:0], way[2:0]} starting at 0. Each cycle it drives:
  - write_wen=1, xstant=1, invl=1, force_way_en=1, force_way=way;
  - write_addr = {AW-4 zeros, set}; data 0.
  - Counter increments every cycle. After the 127 step the state goes to FLDONE.
- fl_busy=1 throughout FLUSH. Requests arriving during FLUSH stay pending (ready=0) and are not dropped.
- fl_req held high after FLDONE starts a new sweep; the requester deasserts on fl_done.

## Timing
- Reset values (async, all outputs): every write_* output 0, force_way_en=0, force_way=0, p0_steal=0, p0_addr=0, ready outputs 0, fl_busy=0, fl_done=0.
  - State resets to INIT with the init counter at 0.
- Write-port outputs are registered: 1-cycle latency from accept.
- Throughput is one accepted op per cycle in IDLE, so back-to-back refills write on consecutive cycles.
- write_wen is 0 in any cycle with no issued op. Idle outputs return to the reset values, except address/data, which may hold.
- Flush latency: fl_req seen in IDLE cycle N → writes in N+1..N+128 → fl_done in N+129 → IDLE in N+130.
- Simultaneous iv_valid and rf_valid: the invalidate goes first and the refill is accepted the next cycle. A refill is never reordered ahead of an earlier-accepted invalidate.
- Reset mid-flush: the sweep is abandoned immediately, no fl_done is produced, and the block re-enters INIT. The DTLB re-initialises itself.
- Set wrap: counter 7'h7F → FLDONE. It never wraps back to set 0 within one sweep.

## Structure
- dtlb_sched_pkg holds:
  - state enum {INIT, IDLE, FLUSH, FLDONE};
  - DTLB_SETS=16, DTLB_WAYS=8, DTLB_INIT_CYCLES=16;
  - the write-command struct {wen, xstant, invl, fway_en, fway, addr, data0..2}.
- One sub-module, dtlb_sched_arb: the combinational fixed-priority grant (fl/iv/rf) producing the ready outputs and the next command. The FSM, counters and output registers stay in the top module.

## Test plan
- Reset release: ready outputs stay 0 for 16 cycles; rf_valid held from cycle 0 is accepted in cycle 16 and write_wen=1 in cycle 17 with xstant=0.
- Simultaneous iv_valid (addr 0x123) and rf_valid (addr 0x456):
  - cycle N: iv accepted, rf_ready=0;
  - cycle N+1: write invl=1, p0_steal=1, p0_addr=0x123;
  - cycle N+2: refill write to 0x456.
- Flush request:
  - 128 consecutive writes with force_way cycling 0..7 per set and set stepping 0..15;
  - fl_done exactly at N+129;
  - rf_valid asserted during the sweep is accepted only after FLDONE.
- Five back-to-back refills: five consecutive write_wen cycles with matching addr/data0..2.
- Reset (rst=0) asserted at sweep step 40: outputs go to 0 asynchronously, no fl_done, and INIT restarts the 16-cycle holdoff.
- Idle with no requests: write_wen=0, p0_steal=0 every cycle.

Source files
------------

// File: rtl/dtlb_sched_pkg.sv
// Shared types and constants for the DTLB write-port scheduler.
package dtlb_sched_pkg;

  localparam int DTLB_SETS        = 16;
  localparam int DTLB_WAYS        = 8;
  localparam int DTLB_INIT_CYCLES = 16;

  // Default DTLB write address and data word widths
  localparam int DTLB_AW = 51;
  localparam int DTLB_DW = 64;

  localparam int SET_W  = $clog2(DTLB_SETS);
  localparam int WAY_W  = $clog2(DTLB_WAYS);
  localparam int STEP_W = SET_W + WAY_W;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    FLUSH  = 2'd2,
    FLDONE = 2'd3
  } state_t;

  // One DTLB write-port command as presented on the write outputs
  typedef struct packed {
    logic               wen;
    logic               xstant;
    logic               invl;
    logic               fway_en;
    logic [WAY_W-1:0]   fway;
    logic [DTLB_AW-1:0] addr;
    logic [DTLB_DW-1:0] data0;
    logic [DTLB_DW-1:0] data1;
    logic [DTLB_DW-1:0] data2;
  } wr_cmd_t;

  // Flush sweep step {set, way} turned into a forced-way invalidate
  function automatic wr_cmd_t flush_step_cmd(input logic [STEP_W-1:0] step);
    wr_cmd_t c;
    c         = '0;
    c.wen     = 1'b1;
    c.xstant  = 1'b1;
    c.invl    = 1'b1;
    c.fway_en = 1'b1;
    c.fway    = step[WAY_W-1:0];
    c.addr    = {{(DTLB_AW-SET_W){1'b0}}, step[STEP_W-1:WAY_W]};
    return c;
  endfunction

endpackage

// File: rtl/dtlb_sched_arb.sv
// Fixed-priority grant between flush, invalidate and refill requesters.
module dtlb_sched_arb
  import dtlb_sched_pkg::*;
#(
  parameter int AW = DTLB_AW,
  parameter int DW = DTLB_DW
) (
  input  logic          issue_en,
  input  logic          fl_req,
  input  logic          iv_valid,
  input  logic [AW-1:0] iv_addr,
  input  logic          rf_valid,
  input  logic [AW-1:0] rf_addr,
  input  logic [DW-1:0] rf_data0,
  input  logic [DW-1:0] rf_data1,
  input  logic [DW-1:0] rf_data2,
  output logic          fl_grant,
  output logic          iv_ready,
  output logic          rf_ready,
  output wr_cmd_t       cmd
);

  // Grant flush first, then invalidate, then refill; build the command to issue
  always_comb begin
    fl_grant = 1'b0;
    iv_ready = 1'b0;
    rf_ready = 1'b0;
    cmd      = '0;
    if (issue_en) begin
      if (fl_req) begin
        fl_grant = 1'b1;
      end else begin
        iv_ready = 1'b1;
        rf_ready = ~iv_valid;
        if (iv_valid) begin
          cmd.wen    = 1'b1;
          cmd.xstant = 1'b1;
          cmd.invl   = 1'b1;
          cmd.addr   = iv_addr;
        end else if (rf_valid) begin
          cmd.wen   = 1'b1;
          cmd.addr  = rf_addr;
          cmd.data0 = rf_data0;
          cmd.data1 = rf_data1;
          cmd.data2 = rf_data2;
        end
      end
    end
  end

endmodule

// File: rtl/dtlb_wr_sched.sv
// DTLB write-port scheduler: init holdoff, request issue and flush sweep.
module dtlb_wr_sched
  import dtlb_sched_pkg::*;
#(
  parameter int AW = DTLB_AW,
  parameter int DW = DTLB_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rf_valid,
  output logic          rf_ready,
  input  logic [AW-1:0] rf_addr,
  input  logic [DW-1:0] rf_data0,
  input  logic [DW-1:0] rf_data1,
  input  logic [DW-1:0] rf_data2,
  input  logic          iv_valid,
  output logic          iv_ready,
  input  logic [AW-1:0] iv_addr,
  input  logic          fl_req,
  output logic          fl_busy,
  output logic          fl_done,
  output logic [AW-1:0] write_addr,
  output logic [DW-1:0] write_data0,
  output logic [DW-1:0] write_data1,
  output logic [DW-1:0] write_data2,
  output logic          write_wen,
  output logic          write_xstant,
  output logic          write_invl,
  output logic          force_way_en,
  output logic [2:0]    force_way,
  output logic          p0_steal,
  output logic [AW-1:0] p0_addr
);

  localparam int                 INIT_W    = $clog2(DTLB_INIT_CYCLES);
  localparam logic [INIT_W-1:0]  INIT_LAST = INIT_W'(DTLB_INIT_CYCLES - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST = '1;

  state_t              state, state_nxt;
  logic [INIT_W-1:0]   init_cnt, init_cnt_nxt;
  logic [STEP_W-1:0]   fl_cnt, fl_cnt_nxt;
  wr_cmd_t             cmd_q, cmd_nxt, arb_cmd;
  logic                fl_grant;

  dtlb_sched_arb #(.AW(AW), .DW(DW)) u_arb (
    .issue_en (state == IDLE),
    .fl_req   (fl_req),
    .iv_valid (iv_valid),
    .iv_addr  (iv_addr),
    .rf_valid (rf_valid),
    .rf_addr  (rf_addr),
    .rf_data0 (rf_data0),
    .rf_data1 (rf_data1),
    .rf_data2 (rf_data2),
    .fl_grant (fl_grant),
    .iv_ready (iv_ready),
    .rf_ready (rf_ready),
    .cmd      (arb_cmd)
  );

  // State, counters and the registered write command
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT;
      init_cnt <= '0;
      fl_cnt   <= '0;
      cmd_q    <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
      fl_cnt   <= fl_cnt_nxt;
      cmd_q    <= cmd_nxt;
    end
  end

  // Next state and next write command; fl_cnt tracks the sweep step on the outputs
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    fl_cnt_nxt   = fl_cnt;
    cmd_nxt      = '0;
    case (state)
      INIT: begin
        if (init_cnt == INIT_LAST) begin
          state_nxt = IDLE;
        end else begin
          init_cnt_nxt = init_cnt + INIT_W'(1);
        end
      end
      IDLE: begin
        if (fl_grant) begin
          state_nxt  = FLUSH;
          fl_cnt_nxt = '0;
          cmd_nxt    = flush_step_cmd('0);
        end else begin
          cmd_nxt = arb_cmd;
        end
      end
      FLUSH: begin
        if (fl_cnt == STEP_LAST) begin
          state_nxt = FLDONE;
        end else begin
          fl_cnt_nxt = fl_cnt + STEP_W'(1);
          cmd_nxt    = flush_step_cmd(fl_cnt + STEP_W'(1));
        end
      end
      FLDONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  assign write_wen    = cmd_q.wen;
  assign write_xstant = cmd_q.xstant;
  assign write_invl   = cmd_q.invl;
  assign force_way_en = cmd_q.fway_en;
  assign force_way    = cmd_q.fway;
  assign write_addr   = cmd_q.addr;
  assign write_data0  = cmd_q.data0;
  assign write_data1  = cmd_q.data1;
  assign write_data2  = cmd_q.data2;
  assign p0_steal     = cmd_q.wen & cmd_q.invl & ~cmd_q.fway_en;
  assign p0_addr      = cmd_q.addr;
  assign fl_busy      = (state == FLUSH);
  assign fl_done      = (state == FLDONE);

endmodule

// File: tb/tb_dtlb_wr_sched.sv
// Self-checking bench for dtlb_wr_sched with a behavioural reference model.
module tb_dtlb_wr_sched;

  localparam int AW       = 51;
  localparam int DW       = 64;
  localparam int SWEEP    = 128;
  localparam int HOLDOFF  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          rf_valid, rf_ready, iv_valid, iv_ready, fl_req, fl_busy, fl_done;
  logic [AW-1:0] rf_addr, iv_addr, write_addr, p0_addr;
  logic [DW-1:0] rf_data0, rf_data1, rf_data2;
  logic [DW-1:0] write_data0, write_data1, write_data2;
  logic          write_wen, write_xstant, write_invl, force_way_en, p0_steal;
  logic [2:0]    force_way;

  always #5 clk = ~clk;

  dtlb_wr_sched #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .rf_valid(rf_valid), .rf_ready(rf_ready), .rf_addr(rf_addr),
    .rf_data0(rf_data0), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .iv_valid(iv_valid), .iv_ready(iv_ready), .iv_addr(iv_addr),
    .fl_req(fl_req), .fl_busy(fl_busy), .fl_done(fl_done),
    .write_addr(write_addr), .write_data0(write_data0),
    .write_data1(write_data1), .write_data2(write_data2),
    .write_wen(write_wen), .write_xstant(write_xstant), .write_invl(write_invl),
    .force_way_en(force_way_en), .force_way(force_way),
    .p0_steal(p0_steal), .p0_addr(p0_addr)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: holdoff cycles left, sweep step on the outputs (-1 none), done pulse
  int  m_init_left;
  int  m_step;
  bit  m_done;
  bit  e_wen, e_xs, e_invl, e_fen, e_steal;
  int  e_fway;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_d0, e_d1, e_d2;

  int  rf_acc_cyc, iv_acc_cyc, fl_done_cyc;
  bit  last_fl_done;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[AW-1:0];
  endfunction

  task automatic applyStimulus(input bit iv_v, input logic [AW-1:0] iv_a,
                               input bit rf_v, input logic [AW-1:0] rf_a, input bit fl);
    iv_valid = iv_v;
    iv_addr  = iv_a;
    rf_valid = rf_v;
    rf_addr  = rf_a;
    rf_data0 = {$urandom(), $urandom()};
    rf_data1 = {$urandom(), $urandom()};
    rf_data2 = {$urandom(), $urandom()};
    fl_req   = fl;
  endtask

  task automatic expect_none();
    e_wen = 0; e_xs = 0; e_invl = 0; e_fen = 0; e_steal = 0; e_fway = 0;
    e_addr = '0; e_d0 = '0; e_d1 = '0; e_d2 = '0;
  endtask

  task automatic model_reset();
    m_init_left = HOLDOFF;
    m_step = -1;
    m_done = 0;
    cyc = 0;
    expect_none();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_wen"}, write_wen, 0);
    checkOutput({tag, "_xstant"}, write_xstant, 0);
    checkOutput({tag, "_invl"}, write_invl, 0);
    checkOutput({tag, "_fway_en"}, force_way_en, 0);
    checkOutput({tag, "_fway"}, force_way, 0);
    checkOutput({tag, "_addr"}, write_addr, 0);
    checkOutput({tag, "_data0"}, write_data0, 0);
    checkOutput({tag, "_p0_steal"}, p0_steal, 0);
    checkOutput({tag, "_p0_addr"}, p0_addr, 0);
    checkOutput({tag, "_rf_ready"}, rf_ready, 0);
    checkOutput({tag, "_iv_ready"}, iv_ready, 0);
    checkOutput({tag, "_fl_busy"}, fl_busy, 0);
    checkOutput({tag, "_fl_done"}, fl_done, 0);
  endtask

  // One clock cycle: check grant outputs mid-cycle, advance model, check write port after edge
  task automatic cycle();
    bit idle;
    @(negedge clk);
    idle = (m_init_left == 0) && (m_step < 0) && !m_done;
    checkOutput("iv_ready", iv_ready, idle && !fl_req);
    checkOutput("rf_ready", rf_ready, idle && !fl_req && !iv_valid);
    checkOutput("fl_busy", fl_busy, m_step >= 0);
    checkOutput("fl_done", fl_done, m_done);
    last_fl_done = fl_done;
    if (fl_done) fl_done_cyc = cyc;
    if (rf_valid && rf_ready) rf_acc_cyc = cyc;
    if (iv_valid && iv_ready) iv_acc_cyc = cyc;

    expect_none();
    if (m_init_left > 0) begin
      m_init_left--;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_step >= 0) begin
      if (m_step == SWEEP - 1) begin
        m_step = -1;
        m_done = 1;
      end else begin
        m_step++;
      end
    end else if (fl_req) begin
      m_step = 0;
    end else if (iv_valid) begin
      e_wen = 1; e_xs = 1; e_invl = 1; e_steal = 1; e_addr = iv_addr;
    end else if (rf_valid) begin
      e_wen = 1; e_addr = rf_addr; e_d0 = rf_data0; e_d1 = rf_data1; e_d2 = rf_data2;
    end
    if (m_step >= 0 && !m_done) begin
      e_wen = 1; e_xs = 1; e_invl = 1; e_fen = 1;
      e_fway = m_step % 8;
      e_addr = AW'(m_step / 8);
    end

    @(posedge clk);
    #1;
    cyc++;
    checkOutput("write_wen", write_wen, e_wen);
    checkOutput("write_xstant", write_xstant, e_xs);
    checkOutput("write_invl", write_invl, e_invl);
    checkOutput("force_way_en", force_way_en, e_fen);
    checkOutput("force_way", force_way, e_fway);
    checkOutput("p0_steal", p0_steal, e_steal);
    if (e_wen) begin
      checkOutput("write_addr", write_addr, e_addr);
      checkOutput("write_data0", write_data0, e_d0);
      checkOutput("write_data1", write_data1, e_d1);
      checkOutput("write_data2", write_data2, e_d2);
    end
    if (e_steal) checkOutput("p0_addr", p0_addr, e_addr);
  endtask

  initial begin
    int n;
    int sweep_writes;
    int wen_run;
    logic [AW-1:0] a;

    rst = 1'b1;
    applyStimulus(0, '0, 0, '0, 0);
    model_reset();
    #2 rst = 1'b0;
    #1 checkResetOutputs("reset");
    repeat (2) @(posedge clk);
    #1;

    // Holdoff: refill held from cycle 0 is taken in cycle 16
    applyStimulus(0, '0, 1, rand_addr(), 0);
    rst = 1'b1;
    model_reset();
    rf_acc_cyc = -1;
    for (int i = 0; i < 24 && rf_acc_cyc < 0; i++) cycle();
    checkOutput("holdoff_accept_cycle", 64'(rf_acc_cyc), 64'(HOLDOFF));
    checkOutput("holdoff_write_wen", write_wen, 1);
    checkOutput("holdoff_write_xstant", write_xstant, 0);
    applyStimulus(0, '0, 0, '0, 0);

    // Idle with no requests
    for (int i = 0; i < 6; i++) begin
      cycle();
      checkOutput("idle_wen", write_wen, 0);
      checkOutput("idle_p0_steal", p0_steal, 0);
    end

    // Invalidate wins over a simultaneous refill
    applyStimulus(1, AW'(51'h123), 1, AW'(51'h456), 0);
    cycle();
    checkOutput("simul_iv_invl", write_invl, 1);
    checkOutput("simul_iv_p0_steal", p0_steal, 1);
    checkOutput("simul_iv_p0_addr", p0_addr, 51'h123);
    iv_valid = 0;
    cycle();
    checkOutput("simul_rf_addr", write_addr, 51'h456);
    checkOutput("simul_rf_invl", write_invl, 0);
    applyStimulus(0, '0, 0, '0, 0);
    cycle();

    // Five back-to-back refills
    wen_run = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, '0, 1, rand_addr(), 0);
      cycle();
      if (write_wen) wen_run++;
    end
    applyStimulus(0, '0, 0, '0, 0);
    cycle();
    checkOutput("b2b_refill_writes", 64'(wen_run), 64'd5);

    // Flush with a refill waiting through the sweep
    a = rand_addr();
    applyStimulus(0, '0, 1, a, 1);
    n = cyc;
    sweep_writes = 0;
    fl_done_cyc = -1;
    rf_acc_cyc = -1;
    for (int i = 0; i < 200 && fl_done_cyc < 0; i++) begin
      cycle();
      if (write_wen && force_way_en) sweep_writes++;
    end
    fl_req = 0;
    cycle();
    rf_valid = 0;
    cycle();
    checkOutput("flush_done_cycle", 64'(fl_done_cyc), 64'(n + SWEEP + 1));
    checkOutput("flush_write_count", 64'(sweep_writes), 64'(SWEEP));
    checkOutput("flush_rf_accept_cycle", 64'(rf_acc_cyc), 64'(n + SWEEP + 2));

    // Random traffic with occasional flushes
    for (int i = 0; i < 500; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, rand_addr(), $urandom_range(0, 1) == 0,
                    rand_addr(), fl_req | ($urandom_range(0, 99) == 0));
      cycle();
      if (last_fl_done) fl_req = 0;
    end
    applyStimulus(0, '0, 0, '0, 0);
    for (int i = 0; i < 200 && (m_step >= 0 || m_done); i++) cycle();
    cycle();

    // Reset during sweep step 40
    applyStimulus(0, '0, 0, '0, 1);
    cycle();
    fl_req = 0;
    for (int i = 0; i < 60 && m_step != 40; i++) cycle();
    checkOutput("midflush_step_reached", 64'(m_step), 64'd40);
    rst = 1'b0;
    #1 checkResetOutputs("midflush_reset");
    @(posedge clk);
    #1;
    rf_valid = 1;
    rf_addr = rand_addr();
    rst = 1'b1;
    model_reset();
    rf_acc_cyc = -1;
    fl_done_cyc = -1;
    for (int i = 0; i < 24 && rf_acc_cyc < 0; i++) cycle();
    checkOutput("midflush_holdoff_accept", 64'(rf_acc_cyc), 64'(HOLDOFF));
    checkOutput("midflush_no_fl_done", 64'(fl_done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(0, '0, 0, '0, 0);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
